// File: rtl/video_frame_monitor.sv
// video_frame_monitor
//   Watches a CE-qualified VGA-style video stream and, once per frame, reports
//   the raster geometry, a checksum over the displayed pixels and whether the
//   geometry has settled. A frame is the span between two VS leading edges.
//
// Ports
//   CLK_VIDEO      video clock (only clock)
//   RESET_N        synchronous active-low reset
//   CE_PIXEL       pixel enable; video inputs are sampled only when high
//   VGA_R/G/B      pixel colour, 8 bits each
//   VGA_HS/VS/DE   syncs (polarity set by *_ACTIVE_HIGH) and display enable
//   frame_done     one-clock pulse when the frame results below update
//   h_total        length of the last line closed before the VS edge
//   v_total        HS leading edges in the frame
//   h_active       DE pixels in the first active line of the frame
//   v_active       lines with at least one DE pixel
//   frame_sum      rotate/xor checksum over the DE pixels of the frame
//   frame_count    published frames since reset (wraps)
//   geom_err       frame had mismatched active widths or a saturated counter
//   locked         geometry matches the previous clean frame
module video_frame_monitor #(
  parameter int CNT_W          = 12,
  parameter int HS_ACTIVE_HIGH = 0,
  parameter int VS_ACTIVE_HIGH = 0
) (
  input  logic             CLK_VIDEO,
  input  logic             RESET_N,
  input  logic             CE_PIXEL,
  input  logic [7:0]       VGA_R,
  input  logic [7:0]       VGA_G,
  input  logic [7:0]       VGA_B,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic             VGA_DE,
  output logic             frame_done,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic [31:0]      frame_sum,
  output logic [15:0]      frame_count,
  output logic             geom_err,
  output logic             locked
);

  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {SEEK, MEASURE, RUN} state_t;
  state_t r_state, w_state_n;

  logic             r_hs_prev, r_vs_prev;
  logic [CNT_W-1:0] r_pix, r_de_run, r_hlen, r_lines, r_act, r_ref;
  logic             r_ref_vld, r_err, r_have_pub;
  logic [31:0]      r_sum;

  logic             w_hs_act, w_vs_act, w_hs_lead, w_vs_lead;
  logic             w_line_active, w_ref_set, w_err_n, w_publish, w_match;
  logic [CNT_W-1:0] w_lines_n, w_act_n, w_ref_n, w_hlen_n;
  logic [31:0]      w_rgb, w_sum_n;

  // Normalise syncs to active-high, then edge-detect against the previous CE sample.
  assign w_hs_act  = (HS_ACTIVE_HIGH != 0) ? VGA_HS : ~VGA_HS;
  assign w_vs_act  = (VS_ACTIVE_HIGH != 0) ? VGA_VS : ~VGA_VS;
  assign w_hs_lead = CE_PIXEL & w_hs_act & ~r_hs_prev;
  assign w_vs_lead = CE_PIXEL & w_vs_act & ~r_vs_prev;

  // Line-close view of the frame accumulators. These already include a line
  // that closes in the same sample as a VS edge, so a coincident HS/VS edge
  // counts the closing line into the frame being published.
  assign w_line_active = w_hs_lead && (r_de_run != '0);
  assign w_lines_n     = (w_hs_lead && r_lines != MAX) ? r_lines + 1'b1 : r_lines;
  assign w_act_n       = (w_line_active && r_act != MAX) ? r_act + 1'b1 : r_act;
  assign w_ref_set     = w_line_active && !r_ref_vld;
  assign w_ref_n       = w_ref_set ? r_de_run : r_ref;
  assign w_hlen_n      = w_hs_lead ? r_pix : r_hlen;
  assign w_err_n       = r_err
                       | (w_hs_lead && r_lines == MAX)
                       | (w_line_active && r_act == MAX)
                       | (CE_PIXEL && !w_hs_lead && r_pix == MAX)
                       | (CE_PIXEL && !w_hs_lead && VGA_DE && r_de_run == MAX)
                       | (w_line_active && r_ref_vld && r_de_run != r_ref);

  assign w_rgb   = {8'h00, VGA_R, VGA_G, VGA_B};
  assign w_sum_n = VGA_DE ? ({r_sum[30:0], r_sum[31]} ^ w_rgb) : r_sum;

  // Lock needs a previous publish that was itself clean, so a bad frame
  // always costs two good frames before relock.
  assign w_match = r_have_pub && !geom_err && !w_err_n &&
                   (w_hlen_n == h_total) && (w_lines_n == v_total) &&
                   (w_ref_n == h_active) && (w_act_n == v_active);

  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) r_state <= SEEK;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_publish = 1'b0;
    case (r_state)
      SEEK:    if (w_vs_lead) w_state_n = MEASURE;
      MEASURE: if (w_vs_lead) begin w_publish = 1'b1; w_state_n = RUN; end
      RUN:     if (w_vs_lead) w_publish = 1'b1;
      default: w_state_n = SEEK;
    endcase
  end

  // Per-CE counters. A line runs from one HS leading edge (inclusive) to the
  // next; the edge sample itself starts the new line.
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_pix     <= '0;
      r_de_run  <= '0;
      r_hlen    <= '0;
      r_lines   <= '0;
      r_act     <= '0;
      r_ref     <= '0;
      r_ref_vld <= 1'b0;
      r_err     <= 1'b0;
      r_sum     <= '0;
    end else if (CE_PIXEL) begin
      r_hs_prev <= w_hs_act;
      r_vs_prev <= w_vs_act;
      r_hlen    <= w_hlen_n;
      if (w_hs_lead) begin
        r_pix    <= CNT_W'(1);
        r_de_run <= CNT_W'(VGA_DE);
      end else begin
        if (r_pix != MAX)                r_pix    <= r_pix + 1'b1;
        if (VGA_DE && r_de_run != MAX)   r_de_run <= r_de_run + 1'b1;
      end
      if (w_vs_lead) begin
        // Current sample belongs to the new frame.
        r_lines   <= '0;
        r_act     <= '0;
        r_ref     <= '0;
        r_ref_vld <= 1'b0;
        r_err     <= 1'b0;
        r_sum     <= VGA_DE ? w_rgb : 32'h0;
      end else begin
        r_lines   <= w_lines_n;
        r_act     <= w_act_n;
        r_ref     <= w_ref_n;
        r_ref_vld <= r_ref_vld | w_ref_set;
        r_err     <= w_err_n;
        r_sum     <= w_sum_n;
      end
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      frame_done  <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      h_active    <= '0;
      v_active    <= '0;
      frame_sum   <= '0;
      frame_count <= '0;
      geom_err    <= 1'b0;
      locked      <= 1'b0;
      r_have_pub  <= 1'b0;
    end else begin
      frame_done <= w_publish;
      if (w_publish) begin
        h_total     <= w_hlen_n;
        v_total     <= w_lines_n;
        h_active    <= w_ref_n;
        v_active    <= w_act_n;
        frame_sum   <= r_sum;
        frame_count <= frame_count + 16'd1;
        geom_err    <= w_err_n;
        locked      <= w_match;
        r_have_pub  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_frame_monitor.sv
module tb_video_frame_monitor;

  logic        CLK_VIDEO = 1'b0;
  logic        RESET_N   = 1'b0;
  logic        CE_PIXEL  = 1'b0;
  logic [7:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
  logic        VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_DE = 1'b0;

  logic        frame_done, geom_err, locked;
  logic [11:0] h_total, v_total, h_active, v_active;
  logic [31:0] frame_sum;
  logic [15:0] frame_count;

  logic        fd8, err8, lk8;
  logic [7:0]  ht8, vt8, ha8, va8;
  logic [31:0] sum8;
  logic [15:0] fc8;

  video_frame_monitor #(.CNT_W(12)) dut (
    .CLK_VIDEO(CLK_VIDEO), .RESET_N(RESET_N), .CE_PIXEL(CE_PIXEL),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
    .frame_done(frame_done), .h_total(h_total), .v_total(v_total),
    .h_active(h_active), .v_active(v_active), .frame_sum(frame_sum),
    .frame_count(frame_count), .geom_err(geom_err), .locked(locked));

  // Narrow-counter instance on the same stream for the saturation case.
  video_frame_monitor #(.CNT_W(8)) dut8 (
    .CLK_VIDEO(CLK_VIDEO), .RESET_N(RESET_N), .CE_PIXEL(CE_PIXEL),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
    .frame_done(fd8), .h_total(ht8), .v_total(vt8),
    .h_active(ha8), .v_active(va8), .frame_sum(sum8),
    .frame_count(fc8), .geom_err(err8), .locked(lk8));

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  typedef struct {
    logic [31:0] ht, vt, ha, va, sum, fc;
    logic        err, lk;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur, prev;
  bit   have_prev;
  int   vs_seen, lines_since_vs, fc_model, ce_mode, fid;
  int   tests = 0, fails = 0, fd_total = 0;
  logic prev_fd = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur = '{default: '0};
    prev = '{default: '0};
    have_prev = 0;
    vs_seen = 0;
    lines_since_vs = 0;
    fc_model = 0;
  endtask

  // Compare process: outputs must always equal the most recently published
  // model record; frame_done pops the next expected record.
  always @(negedge CLK_VIDEO) begin
    if (frame_done === 1'b1) begin
      fd_total++;
      check("fd_width", {31'd0, prev_fd}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL fd_unexpected: got frame_done=1 expected no publish");
      end else begin
        cur = exp_q.pop_front();
      end
    end
    prev_fd = frame_done;
    tests++;
    if (32'(h_total) !== cur.ht || 32'(v_total) !== cur.vt || 32'(h_active) !== cur.ha ||
        32'(v_active) !== cur.va || frame_sum !== cur.sum || 32'(frame_count) !== cur.fc ||
        geom_err !== cur.err || locked !== cur.lk) begin
      fails++;
      $display("FAIL outputs @%0t: got ht=%0d vt=%0d ha=%0d va=%0d sum=%h fc=%0d err=%b lk=%b expected ht=%0d vt=%0d ha=%0d va=%0d sum=%h fc=%0d err=%b lk=%b",
               $time, h_total, v_total, h_active, v_active, frame_sum, frame_count, geom_err, locked,
               cur.ht, cur.vt, cur.ha, cur.va, cur.sum, cur.fc, cur.err, cur.lk);
    end
  end

  task automatic step(bit ce);
    CE_PIXEL = ce;
    @(posedge CLK_VIDEO);
    #1;
  endtask

  // One CE sample, preceded by CE-low gap clocks carrying junk on every input.
  task automatic sample(bit hs, bit vs, bit de, logic [23:0] rgb);
    int g;
    g = (ce_mode == 0) ? 1 : int'($urandom_range(0, 7));
    for (int i = 0; i < g; i++) begin
      {VGA_R, VGA_G, VGA_B} = 24'($urandom);
      VGA_DE = 1'($urandom);
      VGA_HS = 1'($urandom);
      VGA_VS = 1'($urandom);
      step(1'b0);
    end
    {VGA_R, VGA_G, VGA_B} = rgb;
    VGA_DE = de; VGA_HS = hs; VGA_VS = vs;
    step(1'b1);
  endtask

  // Model view of a VS leading edge: closes the window of HS edges and, once
  // the monitor has seen a previous VS edge, predicts a publish.
  task automatic vs_event(int ht, int ha, int va, logic [31:0] sum, bit err);
    rec_t r;
    int   v;
    v = lines_since_vs;
    lines_since_vs = 0;
    if (vs_seen >= 1) begin
      r.ht = 32'(ht); r.vt = 32'(v); r.ha = 32'(ha); r.va = 32'(va);
      r.sum = sum; r.err = err;
      r.fc = 32'((fc_model + 1) & 16'hFFFF);
      r.lk = have_prev && !prev.err && !err && r.ht == prev.ht && r.vt == prev.vt &&
             r.ha == prev.ha && r.va == prev.va;
      exp_q.push_back(r);
      prev = r;
      have_prev = 1;
      fc_model++;
    end
    vs_seen++;
  endtask

  // Frame layout: HS low for pixels 0..3, DE on pixels 8..8+w-1 of lines < va,
  // VS low for two lines starting at (va+2, vs_px). All DE lines lie before
  // this frame's VS edge, so that edge publishes this frame's active area.
  task automatic gen_frame(int ha, int va, int ht, int vt, int bad_line, int bad_w,
                           bit coinc, int cmode, int rst_line);
    logic [31:0] sum;
    logic [23:0] rgb;
    int first_w, nact, w, idx, vs_start;
    bit err, hs, vs, de;
    sum = 0; first_w = -1; nact = 0; err = 0;
    vs_start = (va + 2) * ht + (coinc ? 0 : 20);
    fid++;
    for (int l = 0; l < vt; l++) begin
      if (l == rst_line) begin
        RESET_N = 1'b0;
        step(1'b0);
        model_reset();
        step(1'b0);
        step(1'b0);
        check("rst_fc", 32'(frame_count), 32'd0);
        check("rst_ht", 32'(h_total), 32'd0);
        check("rst_lk", {31'd0, locked}, 32'd0);
        RESET_N = 1'b1;
      end
      w = (l < va) ? ((l == bad_line) ? bad_w : ha) : 0;
      if (w > 0) begin
        if (first_w < 0) first_w = w;
        else if (w != first_w) err = 1;
        nact++;
      end
      for (int p = 0; p < ht; p++) begin
        idx = l * ht + p;
        hs = !(p < 4);
        vs = !(idx >= vs_start && idx < vs_start + 2 * ht);
        de = (p >= 8) && (p < 8 + w);
        case (cmode)
          0:       rgb = 24'h0;
          1:       rgb = 24'((l * 7919) ^ (p * 131) ^ (fid * 17));
          default: rgb = (l == va - 1 && p == 8 + w - 1) ? 24'h123456 : 24'h0;
        endcase
        if (!de) rgb = 24'h0;
        if (p == 0) lines_since_vs++;
        if (de) sum = {sum[30:0], sum[31]} ^ {8'h00, rgb};
        if (idx == vs_start) vs_event(ht, (first_w < 0) ? 0 : first_w, nact, sum, err);
        sample(hs, vs, de, rgb);
      end
    end
  endtask

  initial begin
    model_reset();
    ce_mode = 0;
    fid = 0;
    RESET_N = 1'b0;
    repeat (3) step(1'b0);
    RESET_N = 1'b1;

    // Lock: first VS only arms measurement; two publishes follow.
    gen_frame(16, 12, 40, 20, -1, 0, 0, 1, -1);
    check("seek_no_fd", 32'(fd_total), 32'd0);
    gen_frame(16, 12, 40, 20, -1, 0, 0, 1, -1);
    check("lock_not_first", {31'd0, locked}, 32'd0);
    check("fc_1", 32'(frame_count), 32'd1);
    gen_frame(16, 12, 40, 20, -1, 0, 0, 1, -1);
    check("fd_twice", 32'(fd_total), 32'd2);
    check("lock_ht", 32'(h_total), 32'd40);
    check("lock_vt", 32'(v_total), 32'd20);
    check("lock_ha", 32'(h_active), 32'd16);
    check("lock_va", 32'(v_active), 32'd12);
    check("lock_fc", 32'(frame_count), 32'd2);
    check("lock_set", {31'd0, locked}, 32'd1);

    // Checksum.
    gen_frame(16, 12, 40, 20, -1, 0, 0, 2, -1);
    check("sum_single", frame_sum, 32'h00123456);
    gen_frame(16, 12, 40, 20, -1, 0, 0, 0, -1);
    check("sum_zero", frame_sum, 32'h0);
    check("sum_locked", {31'd0, locked}, 32'd1);

    // Width error, then two clean frames to relock.
    gen_frame(16, 12, 40, 20, 5, 15, 0, 1, -1);
    check("werr_err", {31'd0, geom_err}, 32'd1);
    check("werr_unlock", {31'd0, locked}, 32'd0);
    gen_frame(16, 12, 40, 20, -1, 0, 0, 1, -1);
    check("clean1_err", {31'd0, geom_err}, 32'd0);
    check("clean1_lk", {31'd0, locked}, 32'd0);
    gen_frame(16, 12, 40, 20, -1, 0, 0, 1, -1);
    check("clean2_lk", {31'd0, locked}, 32'd1);

    // Random CE gaps.
    ce_mode = 1;
    gen_frame(16, 12, 40, 20, -1, 0, 0, 1, -1);
    gen_frame(16, 12, 40, 20, -1, 0, 0, 1, -1);
    check("rce_ht", 32'(h_total), 32'd40);
    check("rce_vt", 32'(v_total), 32'd20);
    check("rce_ha", 32'(h_active), 32'd16);
    check("rce_va", 32'(v_active), 32'd12);
    check("rce_lk", {31'd0, locked}, 32'd1);
    ce_mode = 0;

    // Coincident HS/VS edges.
    gen_frame(16, 12, 40, 20, -1, 0, 1, 1, -1);
    check("coinc_vt", 32'(v_total), 32'd20);
    check("coinc_ht", 32'(h_total), 32'd40);
    check("coinc_lk", {31'd0, locked}, 32'd1);
    check("n8_err_clean", {31'd0, err8}, 32'd0);

    // Reset mid-frame: VS later in this frame only re-arms.
    gen_frame(16, 12, 40, 20, -1, 0, 0, 1, 5);
    check("post_rst_fc0", 32'(frame_count), 32'd0);
    gen_frame(16, 12, 40, 20, -1, 0, 0, 1, -1);
    check("post_rst_fc1", 32'(frame_count), 32'd1);
    check("post_rst_lk", {31'd0, locked}, 32'd0);

    // Long lines saturate the narrow instance's pixel counter.
    gen_frame(16, 2, 300, 7, -1, 0, 0, 1, -1);
    check("sat8_ht", 32'(ht8), 32'd255);
    check("sat8_err", {31'd0, err8}, 32'd1);
    check("wide_ht", 32'(h_total), 32'd300);

    VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_DE = 1'b0;
    repeat (4) step(1'b1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
